lsu_mem_responder: RTL

- Target (responder) end of the LSU memory request/response protocol: accepts multi-lane LSU requests and services them from a local word-addressed storage array.
- Returns read responses with the request's lane mask and the tag unchanged.
- Sits behind the LSU memory arbiter outputs as a local-memory or scratchpad bank, and serves as the synthesizable stand-in target in block benches.
- Ports are a flat request/response bundle; the wrapping level binds them to the LSU memory interface fields.

---
 rtl/lsu_mem_pkg.sv | 29 ++
 rtl/lsu_mem_rsp_queue.sv | 39 +++
 rtl/lsu_mem_responder.sv | 74 +++++++
 3 files changed

// File: rtl/lsu_mem_pkg.sv
// lsu_mem_pkg: shared sizes, derived widths and packed request/response records for the LSU memory responder
package lsu_mem_pkg;
  localparam int NUM_LANES = 4;
  localparam int DATA_SIZE = 4;
  localparam int TAG_WIDTH = 8;
  localparam int FLAGS_WIDTH = 1;
  localparam int ADDR_WIDTH = 30;
  localparam int LOG_SIZE = 8;
  localparam int RSP_QUEUE_DEPTH = 4;
  localparam int DATA_WIDTH = 8 * DATA_SIZE;
  localparam int RSP_DATAW = NUM_LANES * (1 + DATA_WIDTH) + TAG_WIDTH;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_SIZE-1:0] byteen;
    logic [FLAGS_WIDTH-1:0] flags;
  } req_lane_t;
  typedef struct packed {
    logic rw;
    logic [NUM_LANES-1:0] mask;
    req_lane_t [NUM_LANES-1:0] lanes;
    logic [TAG_WIDTH-1:0] tag;
  } req_t;
  typedef struct packed {
    logic [NUM_LANES-1:0] mask;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0] tag;
  } rsp_t;
endpackage

// File: rtl/lsu_mem_rsp_queue.sv
// lsu_mem_rsp_queue: registered FIFO (clk, active-low async reset; in_valid/in_data/in_ready push side, out_valid/out_data/out_ready pop side)
module lsu_mem_rsp_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic push, pop;
  always_comb begin
    in_ready = (wr_q - rd_q) != FULL;
    out_valid = wr_q != rd_q;
    out_data = mem_q[rd_q[AW-1:0]];
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= in_data;
endmodule

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder: LSU memory target on a 2**LOG_SIZE-word store (req_* in, req_ready out, rsp_* out echoing mask/tag, rsp_ready in, active-low async reset); LSU_MEM_WRITE_ACK_EN makes writes respond too
module lsu_mem_responder
  import lsu_mem_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  input  logic                               req_rw,
  input  logic [NUM_LANES-1:0]               req_mask,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_LANES*DATA_SIZE-1:0]     req_byteen,
  input  logic [NUM_LANES*FLAGS_WIDTH-1:0]   req_flags,
  input  logic [TAG_WIDTH-1:0]               req_tag,
  output logic                               req_ready,
  output logic                               rsp_valid,
  output logic [NUM_LANES-1:0]               rsp_mask,
  output logic [NUM_LANES*DATA_WIDTH-1:0]    rsp_data,
  output logic [TAG_WIDTH-1:0]               rsp_tag,
  input  logic                               rsp_ready
);
`ifdef LSU_MEM_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif
  localparam int CW = $clog2(RSP_QUEUE_DEPTH) + 1;
  logic [DATA_WIDTH-1:0] mem_q [2**LOG_SIZE];
  logic [CW-1:0] credits_q, credits_d;
  logic s1_valid_q, s1_valid_d;
  rsp_t s1_q, s1_d, q_out;
  logic produce, q_in_ready, unused_bits;
  assign unused_bits = ^{req_flags, req_addr, q_in_ready};
  always_comb begin
    req_ready = reset && ((req_rw && !WR_ACK) || credits_q != '0);
    produce = req_valid && req_ready && (!req_rw || WR_ACK);
    credits_d = credits_q - CW'(produce) + CW'(rsp_valid && rsp_ready);
    s1_valid_d = produce;
    s1_d.mask = req_mask;
    s1_d.tag = req_tag;
    for (int i = 0; i < NUM_LANES; i++)
      s1_d.data[i] = (req_rw || !req_mask[i]) ? '0 : mem_q[req_addr[i*ADDR_WIDTH +: LOG_SIZE]];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      credits_q <= CW'(RSP_QUEUE_DEPTH);
      s1_valid_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      s1_valid_q <= s1_valid_d;
    end
  always_ff @(posedge clk) s1_q <= s1_d;
  always_ff @(posedge clk)
    if (req_valid && req_ready && req_rw)
      for (int i = 0; i < NUM_LANES; i++)
        for (int b = 0; b < DATA_SIZE; b++)
          if (req_mask[i] && req_byteen[i*DATA_SIZE+b])
            mem_q[req_addr[i*ADDR_WIDTH +: LOG_SIZE]][b*8 +: 8] <= req_data[(i*DATA_SIZE+b)*8 +: 8];
  lsu_mem_rsp_queue #(.WIDTH(RSP_DATAW), .DEPTH(RSP_QUEUE_DEPTH)) u_queue (
    .clk(clk),
    .reset(reset),
    .in_valid(s1_valid_q),
    .in_data(s1_q),
    .in_ready(q_in_ready),
    .out_valid(rsp_valid),
    .out_data(q_out),
    .out_ready(rsp_ready)
  );
  always_comb begin
    rsp_mask = q_out.mask;
    rsp_data = q_out.data;
    rsp_tag = q_out.tag;
  end
endmodule
